// File: rtl/priority_encoder_rr_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Mode selectors, index-width derivation and the multi-hit test.
package prio_enc_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;
  localparam int unsigned MAX_N      = 256;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clearing the lowest set bit leaves a nonzero value iff two or more bits were set.
  function automatic logic popcount_gt1(input logic [MAX_N-1:0] vec);
    return (vec & (vec - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/priority_encoder_rr_if.sv
// Request/result handshake bundle between a request source and the encoder.
// slave is the encoder side, master the producer/consumer side.
interface priority_encoder_rr_if
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
);

  localparam int unsigned IDX_W = idx_w(N);

  logic             enable;
  logic [N-1:0]     d_in;
  logic [IDX_W-1:0] y_out;
  logic             y_valid;
  logic             y_ready;
  logic             multi_hit;

  modport master (
    output enable, d_in, y_ready,
    input  y_out, y_valid, multi_hit
  );

  modport slave (
    input  enable, d_in, y_ready,
    output y_out, y_valid, multi_hit
  );

endinterface

// File: rtl/priority_encoder_rr_find.sv
// Combinational circular search: first set bit of req going downward from start,
// wrapping from 0 to N-1 (modulo N, not modulo 2^IDX_W).
module prio_find
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(N - 1);

  logic [IDX_W-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = start;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = (pos == '0) ? TOP : pos - 1'b1;
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed (MSB wins) or round-robin,
// with a one-deep valid/ready output stage and a multi-hit flag.
module priority_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N       = 8,
  parameter  int unsigned RR_MODE = MODE_FIXED,
  localparam int unsigned IDX_W   = idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  priority_encoder_rr_if.slave  bus
);

  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N - 1);
  localparam bit               IS_RR    = (RR_MODE == MODE_RR);

  logic [IDX_W-1:0] y_out_q, y_out_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             y_valid_q, y_valid_d;
  logic             multi_q, multi_d;
  logic [IDX_W-1:0] start, win;
  logic             found, cap;

  // Fixed mode is the round-robin search pinned to start at N-1.
  assign start = IS_RR ? ptr_q : PTR_INIT;

  prio_find #(.N(N)) u_find (
    .req   (bus.d_in),
    .start (start),
    .idx   (win),
    .found (found)
  );

  assign cap = bus.enable && found && (!y_valid_q || bus.y_ready);

  always_comb begin
    y_out_d   = y_out_q;
    y_valid_d = y_valid_q;
    multi_d   = multi_q;
    ptr_d     = ptr_q;
    if (cap) begin
      y_out_d   = win;
      y_valid_d = 1'b1;
      multi_d   = popcount_gt1(MAX_N'(bus.d_in));
      // The winner drops to lowest priority on the next search.
      if (IS_RR) begin
        ptr_d = (win == '0) ? PTR_INIT : win - 1'b1;
      end else begin
        ptr_d = PTR_INIT;
      end
    end else if (y_valid_q && bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      multi_q   <= 1'b0;
      ptr_q     <= PTR_INIT;
    end else begin
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      multi_q   <= multi_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.y_out     = y_out_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.multi_hit = multi_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Self-checking bench: fixed N=4, round-robin N=4 and round-robin N=5 encoders
// driven by directed tables/sequences and by random stimulus against a reference model.
module tb_priority_encoder_rr;
  import prio_enc_pkg::*;

  logic clk;
  logic rst_n;

  priority_encoder_rr_if #(.N(4)) f4 ();
  priority_encoder_rr_if #(.N(4)) r4 ();
  priority_encoder_rr_if #(.N(5)) r5 ();

  priority_encoder_rr #(.N(4), .RR_MODE(MODE_FIXED)) dut_f4 (.clk(clk), .rst_n(rst_n), .bus(f4));
  priority_encoder_rr #(.N(4), .RR_MODE(MODE_RR))    dut_r4 (.clk(clk), .rst_n(rst_n), .bus(r4));
  priority_encoder_rr #(.N(5), .RR_MODE(MODE_RR))    dut_r5 (.clk(clk), .rst_n(rst_n), .bus(r5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  d;
    int          y;
    logic        m;
  } vec_t;
  vec_t tbl[10];

  // Reference model state, one slot per DUT (0: fixed N=4, 1: rr N=4, 2: rr N=5).
  int   mn[3]  = '{4, 4, 5};
  bit   mrr[3] = '{1'b0, 1'b1, 1'b1};
  logic mv[3];
  int   my[3];
  logic mm[3];
  int   mlast[3];
  int   in_en[3], in_d[3], in_rdy[3];

  task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int k, input logic ev, input int ey, input logic em);
    logic        av, am;
    logic [31:0] ay;
    case (k)
      0:       begin av = f4.y_valid; ay = 32'(f4.y_out); am = f4.multi_hit; end
      1:       begin av = r4.y_valid; ay = 32'(r4.y_out); am = r4.multi_hit; end
      default: begin av = r5.y_valid; ay = 32'(r5.y_out); am = r5.multi_hit; end
    endcase
    cmp(tag, "y_valid", {31'b0, av}, {31'b0, ev});
    cmp(tag, "y_out", ay, ey);
    cmp(tag, "multi_hit", {31'b0, am}, {31'b0, em});
  endtask

  task automatic set_in(input int k, input int en, input int d, input int rdy);
    in_en[k] = en; in_d[k] = d; in_rdy[k] = rdy;
    case (k)
      0:       begin f4.enable = (en != 0); f4.d_in = 4'(d); f4.y_ready = (rdy != 0); end
      1:       begin r4.enable = (en != 0); r4.d_in = 4'(d); r4.y_ready = (rdy != 0); end
      default: begin r5.enable = (en != 0); r5.d_in = 5'(d); r5.y_ready = (rdy != 0); end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; my[k] = 0; mm[k] = 1'b0; mlast[k] = mn[k];
    end
  endtask

  function automatic int hi_set(input int d, input int lim);
    for (int i = lim - 1; i >= 0; i--)
      if (((d >> i) & 1) != 0) return i;
    return -1;
  endfunction

  // Round-robin as "highest requester below the last winner, else highest overall".
  task automatic model_step(input int k);
    int  w;
    bit  c;
    c = (in_en[k] != 0) && (in_d[k] != 0) && (!mv[k] || (in_rdy[k] != 0));
    if (c) begin
      w = mrr[k] ? hi_set(in_d[k], mlast[k]) : -1;
      if (w < 0) w = hi_set(in_d[k], mn[k]);
      my[k] = w;
      mv[k] = 1'b1;
      mm[k] = ($countones(in_d[k]) > 1);
      if (mrr[k]) mlast[k] = w;
    end else if (mv[k] && (in_rdy[k] != 0)) begin
      mv[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) set_in(k, 0, 0, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{d: 4'b0101, y: 2, m: 1'b1};
    tbl[1] = '{d: 4'b0001, y: 0, m: 1'b0};
    for (int unsigned p = 0; p < 8; p++) begin
      tbl[2 + p].d = 4'(8 + p);
      tbl[2 + p].y = 3;
      tbl[2 + p].m = (p != 0);
    end

    // Reset and idle with no requests.
    do_reset();
    chk_out("reset", 0, 1'b0, 0, 1'b0);
    set_in(0, 1, 0, 1);
    repeat (2) begin
      tick();
      chk_out("idle", 0, 1'b0, 0, 1'b0);
    end

    // Fixed priority table, back-to-back captures.
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1, int'(tbl[i].d), 1);
      tick();
      chk_out("prio", 0, 1'b1, tbl[i].y, tbl[i].m);
    end

    // Stall holds output; release captures on the same edge.
    set_in(0, 1, 4'b0010, 1);
    tick();
    chk_out("stall cap", 0, 1'b1, 1, 1'b0);
    set_in(0, 1, 4'b1000, 0);
    repeat (3) begin
      tick();
      chk_out("stall hold", 0, 1'b1, 1, 1'b0);
    end
    set_in(0, 1, 4'b1000, 1);
    tick();
    chk_out("stall release", 0, 1'b1, 3, 1'b0);
    set_in(0, 1, 0, 1);
    tick();
    chk_out("accept", 0, 1'b0, 3, 1'b0);

    // Enable gating, then async reset mid-cycle while valid.
    set_in(0, 0, 4'b0100, 1);
    repeat (2) begin
      tick();
      chk_out("en gate", 0, 1'b0, 3, 1'b0);
    end
    set_in(0, 1, 4'b0100, 1);
    tick();
    chk_out("en cap", 0, 1'b1, 2, 1'b0);
    set_in(0, 1, 4'b0100, 0);
    #3 rst_n = 1'b0;
    #1 chk_out("async rst", 0, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk_out("post rst", 0, 1'b1, 2, 1'b0);

    // Round-robin N=4, all requesting; reset mid-rotation must restore the pointer.
    do_reset();
    set_in(1, 1, 4'b1111, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("rr 1111", 1, 1'b1, 3 - (i % 4), 1'b1);
    end
    #3 rst_n = 1'b0;
    #1 chk_out("rr async rst", 1, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk_out("rr ptr reset", 1, 1'b1, 3, 1'b1);

    do_reset();
    set_in(1, 1, 4'b1001, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("rr 1001", 1, 1'b1, (i % 2 == 0) ? 3 : 0, 1'b1);
    end

    // Round-robin N=5: pointer wraps at 4.
    do_reset();
    set_in(2, 1, 5'b10001, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("rr5 10001", 2, 1'b1, (i % 2 == 0) ? 4 : 0, 1'b1);
    end

    // Random stimulus on all three DUTs against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        set_in(k,
               ($urandom_range(0, 3) != 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << mn[k]) - 1)),
               ($urandom_range(0, 3) != 0) ? 1 : 0);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
      for (int k = 0; k < 3; k++) chk_out("random", k, mv[k], my[k], mm[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
